// File: rtl/time_set_ctrl.sv
// time_set_ctrl: pushbutton front end for the alarm clock core.
// Synchronizes and debounces five raw buttons, walks the user through BCD
// hour then minute entry, and issues a LOAD_CYCLES-long load strobe to
// either the time counter or the alarm register.
// Optional build macro: AUTO_REPEAT_EN (held inc auto-repeats while editing).
//
// state  | meaning
// IDLE   | waiting for set (edit time) or mode (edit alarm)
// EDIT_H | inc steps the hour field, set advances, mode aborts
// EDIT_M | inc steps the minute field, set commits, mode aborts
// LOAD   | strobe LD_time or LD_alarm for LOAD_CYCLES cycles
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOAD_CYCLES     = 2,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alm,
  input  logic       btn_stop,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       AL_ON,
  output logic       STOP_al,
  output logic [1:0] edit_state
);

  localparam int NB = 5;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [DW-1:0] DB_RELOAD = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LD_RELOAD = LW'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EDIT_H = 2'b01,
    EDIT_M = 2'b10,
    LOAD   = 2'b11
  } state_t;

  // Bit order: 0 set, 1 mode, 2 inc, 3 alm, 4 stop.
  logic [NB-1:0] raw, sync_a, sync_b, db;
  logic [3:0]    db_q, press;
  logic [DW-1:0] db_cnt [NB];

  state_t        state, state_next;
  logic          tgt_alarm, tgt_next;
  logic [LW-1:0] load_cnt;
  logic          load_go, hr_step, mn_step, inc_evt, al_on;

  assign raw = {btn_stop, btn_alm, btn_inc, btn_mode, btn_set};

  // Two-flop synchronizers on the raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: down-counter reloads whenever the synchronized level matches
  // the accepted level; a mismatch held for DEBOUNCE_CYCLES samples is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NB; i++) db_cnt[i] <= DB_RELOAD;
      db   <= '0;
      db_q <= '0;
    end else begin
      db_q <= db[3:0];
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= DB_RELOAD;
        end else if (db_cnt[i] == '0) begin
          db[i]     <= sync_b[i];
          db_cnt[i] <= DB_RELOAD;
        end else begin
          db_cnt[i] <= db_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign press = db[3:0] & ~db_q;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_arm, rpt_fire, in_edit;

  assign in_edit  = (state == EDIT_H) || (state == EDIT_M);
  assign rpt_fire = rpt_arm && (rpt_cnt == '0);
  assign inc_evt  = press[2] | rpt_fire;

  // Auto-repeat timer: armed by an inc press, first fire after REPEAT_DELAY,
  // then every REPEAT_PERIOD; dropped on release or any state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_arm <= 1'b0;
      rpt_cnt <= '0;
    end else if (!db[2] || !in_edit || (state_next != state)) begin
      rpt_arm <= 1'b0;
      rpt_cnt <= '0;
    end else if (press[2]) begin
      rpt_arm <= 1'b1;
      rpt_cnt <= RW'(REPEAT_DELAY - 1);
    end else if (rpt_fire) begin
      rpt_cnt <= RW'(REPEAT_PERIOD - 1);
    end else if (rpt_arm) begin
      rpt_cnt <= rpt_cnt - 1'b1;
    end
  end
`else
  assign inc_evt = press[2];
`endif

  // Alarm enable toggles on every alm press regardless of edit state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) al_on <= 1'b0;
    else if (press[3]) al_on <= ~al_on;
  end

  // FSM state, load target and strobe length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tgt_alarm <= 1'b0;
      load_cnt  <= '0;
    end else begin
      state     <= state_next;
      tgt_alarm <= tgt_next;
      if (load_go) load_cnt <= LD_RELOAD;
      else if ((state == LOAD) && (load_cnt != '0)) load_cnt <= load_cnt - 1'b1;
    end
  end

  // Next-state decode; set beats mode beats inc within one cycle.
  always_comb begin
    state_next = state;
    tgt_next   = tgt_alarm;
    load_go    = 1'b0;
    hr_step    = 1'b0;
    mn_step    = 1'b0;
    case (state)
      IDLE: begin
        if (press[0]) begin
          state_next = EDIT_H;
          tgt_next   = 1'b0;
        end else if (press[1]) begin
          state_next = EDIT_H;
          tgt_next   = 1'b1;
        end
      end
      EDIT_H: begin
        if (press[0])      state_next = EDIT_M;
        else if (press[1]) state_next = IDLE;
        else if (inc_evt)  hr_step = 1'b1;
      end
      EDIT_M: begin
        if (press[0]) begin
          state_next = LOAD;
          load_go    = 1'b1;
        end else if (press[1]) begin
          state_next = IDLE;
        end else if (inc_evt) begin
          mn_step = 1'b1;
        end
      end
      LOAD: begin
        if (load_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // BCD digit registers; hour wraps 23->00, minute wraps 59->00 with no carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      H_in1 <= '0;
      H_in0 <= '0;
      M_in1 <= '0;
      M_in0 <= '0;
    end else begin
      if (hr_step) begin
        if ((H_in1 == 2'd2) && (H_in0 == 4'd3)) begin
          H_in1 <= '0;
          H_in0 <= '0;
        end else if (H_in0 == 4'd9) begin
          H_in1 <= H_in1 + 2'd1;
          H_in0 <= '0;
        end else begin
          H_in0 <= H_in0 + 4'd1;
        end
      end
      if (mn_step) begin
        if (M_in0 == 4'd9) begin
          M_in0 <= '0;
          M_in1 <= (M_in1 == 4'd5) ? 4'd0 : M_in1 + 4'd1;
        end else begin
          M_in0 <= M_in0 + 4'd1;
        end
      end
    end
  end

  assign LD_time    = (state == LOAD) && !tgt_alarm;
  assign LD_alarm   = (state == LOAD) && tgt_alarm;
  assign AL_ON      = al_on;
  assign STOP_al    = db[4];
  assign edit_state = state;

endmodule
